// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: Moore FSM sequencing the 16-bit ALU/regfile datapath, one instruction at a time.
// Outputs are registered from next state and next ir, so they always reflect the current state.
module alu_instr_sequencer #(
    parameter int DW           = 16,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [15:0]   instr,
    output logic          w,
    output logic          err,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] sximm8
);
    typedef enum logic [2:0] {S_WAIT, S_DECODE, S_MOVI, S_GETA, S_GETB, S_EXEC, S_WRITE, S_HALT} state_t;
    state_t      r_state, w_state;
    logic [15:0] r_ir, w_ir;
    logic        w_movi, w_mov, w_mvn, w_alu, w_cmp, w_illegal;
    assign w_ir      = (r_state == S_WAIT && s) ? instr : r_ir;
    assign w_movi    = w_ir[15:13] == 3'b110 && w_ir[12:11] == 2'b10;
    assign w_mov     = w_ir[15:13] == 3'b110 && w_ir[12:11] == 2'b00;
    assign w_mvn     = w_ir[15:13] == 3'b101 && w_ir[12:11] == 2'b11;
    assign w_alu     = w_ir[15:13] == 3'b101 && w_ir[12:11] != 2'b11;
    assign w_cmp     = w_ir[15:13] == 3'b101 && w_ir[12:11] == 2'b01;
    assign w_illegal = !(w_movi || w_mov || w_mvn || w_alu);
    assign sximm8    = {{(DW-8){r_ir[7]}}, r_ir[7:0]};
    always_comb begin
        w_state = r_state;
        case (r_state)
            S_WAIT:          w_state = s ? S_DECODE : S_WAIT;
            S_DECODE:        w_state = w_movi ? S_MOVI : (w_mov || w_mvn) ? S_GETB : w_alu ? S_GETA :
                                       ILLEGAL_TRAP ? S_HALT : S_WAIT;
            S_GETA:          w_state = S_GETB;
            S_GETB:          w_state = S_EXEC;
            S_EXEC:          w_state = w_cmp ? S_WAIT : S_WRITE;
            S_MOVI, S_WRITE: w_state = S_WAIT;
            default:         w_state = S_HALT;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_WAIT;
            r_ir     <= '0;
            w        <= 1'b1;
            err      <= 1'b0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            vsel     <= '0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            shift    <= '0;
            ALUop    <= '0;
        end else begin
            r_state  <= w_state;
            r_ir     <= w_ir;
            w        <= w_state == S_WAIT;
            err      <= w_state == S_HALT || (w_state == S_DECODE && w_illegal);
            readnum  <= w_state == S_GETA ? w_ir[10:8] : w_state == S_GETB ? w_ir[2:0] : 3'd0;
            writenum <= w_state == S_MOVI ? w_ir[10:8] : w_state == S_WRITE ? w_ir[7:5] : 3'd0;
            write    <= w_state == S_MOVI || w_state == S_WRITE;
            vsel     <= {1'b0, w_state == S_MOVI};
            loada    <= w_state == S_GETA;
            loadb    <= w_state == S_GETB;
            loadc    <= w_state == S_EXEC && !w_cmp;
            loads    <= w_state == S_EXEC && w_cmp;
            // MOV reg and MVN pass B through the ALU with A forced to zero
            asel     <= w_state == S_EXEC && (w_ir[15:13] == 3'b110 || w_ir[12:11] == 2'b11);
            bsel     <= 1'b0;
            shift    <= w_state == S_EXEC ? w_ir[4:3] : 2'b00;
            ALUop    <= w_state == S_EXEC ? (w_ir[15:13] == 3'b110 ? 2'b00 : w_ir[12:11]) : 2'b00;
        end
    end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench; an instruction-level model queues the expected
// output vector of every busy cycle, and a negedge monitor pops and compares them.
module tb_alu_instr_sequencer;
    typedef struct packed {
        logic        w, err;
        logic [2:0]  readnum, writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  shift, aluop;
        logic [15:0] sximm8;
    } outs_t;

    logic        clk = 0, rst_n = 1, s = 0, rst1_n = 1, s1 = 0;
    logic [15:0] instr = '0, instr1 = '0, last_ir = '0;
    logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;
    logic        w1, err1, write1, loada1, loadb1, loadc1, loads1, asel1, bsel1;
    logic [2:0]  readnum1, writenum1;
    logic [1:0]  vsel1, shift1, aluop1;
    logic [15:0] sximm81;
    outs_t       act0, act1, exp_q[$];
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    alu_instr_sequencer #(.DW(16), .ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .reset(rst_n), .s(s), .instr(instr), .w(w), .err(err), .readnum(readnum),
        .writenum(writenum), .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(aluop),
        .sximm8(sximm8));

    alu_instr_sequencer #(.DW(16), .ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(rst1_n), .s(s1), .instr(instr1), .w(w1), .err(err1), .readnum(readnum1),
        .writenum(writenum1), .write(write1), .vsel(vsel1), .loada(loada1), .loadb(loadb1),
        .loadc(loadc1), .loads(loads1), .asel(asel1), .bsel(bsel1), .shift(shift1), .ALUop(aluop1),
        .sximm8(sximm81));

    assign act0 = {w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                   shift, aluop, sximm8};
    assign act1 = {w1, err1, readnum1, writenum1, write1, vsel1, loada1, loadb1, loadc1, loads1,
                   asel1, bsel1, shift1, aluop1, sximm81};

    function automatic outs_t idle(input logic [15:0] ir);
        outs_t o = '0;
        o.w = 1'b1;
        o.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return o;
    endfunction

    task automatic check(input string nm, input outs_t got, input outs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    // Expected busy-cycle sequence derived from the instruction class
    task automatic push_model(input logic [15:0] x);
        logic [2:0] opc = x[15:13];
        logic [1:0] op = x[12:11];
        bit movi = opc == 3'b110 && op == 2'b10;
        bit movr = opc == 3'b110 && op == 2'b00;
        bit alu = opc == 3'b101;
        bit mvn = alu && op == 2'b11;
        bit cmp = alu && op == 2'b01;
        outs_t b, o;
        b = idle(x);
        b.w = 1'b0;
        o = b;
        o.err = !(movi || movr || alu);
        exp_q.push_back(o);
        if (movi) begin
            o = b; o.write = 1; o.writenum = x[10:8]; o.vsel = 2'b01;
            exp_q.push_back(o);
        end else if (movr || alu) begin
            if (alu && !mvn) begin
                o = b; o.readnum = x[10:8]; o.loada = 1;
                exp_q.push_back(o);
            end
            o = b; o.readnum = x[2:0]; o.loadb = 1;
            exp_q.push_back(o);
            o = b; o.shift = x[4:3]; o.aluop = movr ? 2'b00 : op; o.asel = movr || mvn;
            o.loadc = !cmp; o.loads = cmp;
            exp_q.push_back(o);
            if (!cmp) begin
                o = b; o.write = 1; o.writenum = x[7:5];
                exp_q.push_back(o);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) check("reset", act0, idle(16'h0));
        else if (w && exp_q.size() == 0) check("idle", act0, idle(last_ir));
        else if (exp_q.size() == 0) check("unexpected_step", act0, idle(last_ir));
        else check("step", act0, exp_q.pop_front());
    end

    task automatic wait_idle();
        for (int n = 0; n < 20 && !w; n++) @(negedge clk);
        if (!w) begin
            miscompares++;
            $display("FAIL wait_idle: w stuck at %b, want 1", w);
        end
    endtask

    task automatic issue(input logic [15:0] x, input bit hold);
        wait_idle();
        #1 instr = x; s = 1; push_model(x);
        @(negedge clk);
        #1 last_ir = x;
        for (int n = 0; n < 10 && !w; n++) begin
            instr = 16'($urandom);
            s = hold | 1'($urandom);
            @(negedge clk);
            #1;
        end
        s = 0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: r[15:13] = 3'b110;
            1, 2: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        outs_t e;
        #1 rst_n = 0; rst1_n = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        issue(16'hD0FD, 1);
        issue(16'hA148, 1);
        issue(16'hA901, 1);
        issue(16'hB8E1, 1);
        issue(16'h0000, 1);
        // abort an ADD in GETB; no write may follow
        wait_idle();
        #1 instr = 16'hA148; s = 1; push_model(instr);
        @(negedge clk);
        #1 s = 0; last_ir = instr;
        repeat (2) @(negedge clk);
        #2 rst_n = 0; exp_q.delete(); last_ir = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        repeat (200) begin
            issue(rand_instr(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected steps not seen, want 0", exp_q.size());
        end
        // trapping instance: illegal opcode halts until reset
        #1 rst1_n = 1;
        @(negedge clk);
        check("t1_idle", act1, idle(16'h0));
        #1 instr1 = 16'h0000; s1 = 1;
        e = idle(16'h0); e.w = 0; e.err = 1;
        @(negedge clk);
        check("t1_decode", act1, e);
        #1 instr1 = 16'hD0FD;
        repeat (5) begin
            @(negedge clk);
            check("t1_halt", act1, e);
        end
        #2 rst1_n = 0; s1 = 0;
        @(negedge clk);
        check("t1_reset", act1, idle(16'h0));
        #1 rst1_n = 1;
        @(negedge clk);
        check("t1_after", act1, idle(16'h0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
